scan_sequencer: RTL and testbench

- Synchronous 3-bit code generator that drives the select input of the team's 3-to-8 decoder (a[2:0] -> one-hot x[7:0]).
- Steps through codes 0..7 (up) or 7..0 (down) at a programmable rate.
- Modes: one-shot sweep or continuous scan.
- Start/stop control with busy/done status, for LED and digit scanning.

---
 rtl/scan_sequencer.sv | 125 ++++++++++++
 tb/tb_scan_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit decoder select code up or down at a rate of DIV
// clocks per code, one-shot or continuous. Define SCAN_HOLD_EN to add a freeze input.
module scan_sequencer #(
   parameter int unsigned DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       mode,
   input  logic       dir,
`ifdef SCAN_HOLD_EN
   input  logic       hold,
`endif
   output logic [2:0] a,
   output logic       valid,
   output logic       busy,
   output logic       done,
   output logic       wrap
);

   localparam logic [7:0] PrescMax = 8'(DIV - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e     state_q, state_d;
   logic [7:0] presc_q, presc_d;
   logic [2:0] a_q, a_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       wrap_q, wrap_d;
   logic       mode_q, mode_d;
   logic       dir_q, dir_d;
   logic       last_code;

   // Final code of a sweep depends on the direction latched at start.
   assign last_code = dir_q ? (a_q == 3'd0) : (a_q == 3'd7);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      a_d     = a_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start && !stop) begin
               state_d = StRun;
               mode_d  = mode;
               dir_d   = dir;
               a_d     = dir ? 3'd7 : 3'd0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               presc_d = 8'd0;
            end
         end
         StRun: begin
            if (stop) begin
               state_d = StIdle;
               a_d     = 3'd0;
               valid_d = 1'b0;
               busy_d  = 1'b0;
               presc_d = 8'd0;
`ifdef SCAN_HOLD_EN
            end else if (hold) begin
               presc_d = presc_q;
`endif
            end else if (presc_q != PrescMax) begin
               presc_d = presc_q + 8'd1;
            end else begin
               presc_d = 8'd0;
               if (!last_code) begin
                  a_d = dir_q ? a_q - 3'd1 : a_q + 3'd1;
               end else if (!mode_q) begin
                  state_d = StIdle;
                  a_d     = 3'd0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  a_d    = dir_q ? 3'd7 : 3'd0;
                  wrap_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         presc_q <= 8'd0;
         a_q     <= 3'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         mode_q  <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         a_q     <= a_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         mode_q  <= mode_d;
         dir_q   <= dir_d;
      end
   end

   assign a     = a_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: directed scenarios then random control traffic,
// checked cycle by cycle against a sweep-position reference model.
module tb_scan_sequencer;

   localparam int unsigned Div = 4;
`ifdef SCAN_HOLD_EN
   localparam bit HoldEn = 1'b1;
`else
   localparam bit HoldEn = 1'b0;
`endif

   typedef struct packed {
      logic [2:0] a;
      logic       valid;
      logic       busy;
      logic       done;
      logic       wrap;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst, start, stop, mode, dir, hold;
   logic [2:0] a;
   logic       valid, busy, done, wrap;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;

   // Reference model: position k along the sweep plus cycles spent on the current code.
   bit   m_run  = 1'b0;
   bit   m_mode = 1'b0;
   bit   m_dir  = 1'b0;
   int   m_k    = 0;
   int   m_cnt  = 0;

   always #5 clk = ~clk;

   scan_sequencer #(.DIV(Div)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .stop  (stop),
      .mode  (mode),
      .dir   (dir),
`ifdef SCAN_HOLD_EN
      .hold  (hold),
`endif
      .a     (a),
      .valid (valid),
      .busy  (busy),
      .done  (done),
      .wrap  (wrap)
   );

   task automatic step(input logic r, input logic s, input logic p, input logic md,
                       input logic dr, input logic h);
      exp_t e;
      rst = r; start = s; stop = p; mode = md; dir = dr; hold = h;
      @(posedge clk);
      cycle++;
      e = '0;
      if (r) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         if (s && !p) begin
            m_run = 1'b1; m_mode = md; m_dir = dr; m_k = 0; m_cnt = 0;
         end
      end else if (p) begin
         m_run = 1'b0;
      end else if (!(HoldEn && h)) begin
         m_cnt++;
         if (m_cnt == int'(Div)) begin
            m_cnt = 0;
            m_k++;
            if (m_k == 8) begin
               if (!m_mode) begin
                  m_run  = 1'b0;
                  e.done = 1'b1;
               end else begin
                  m_k    = 0;
                  e.wrap = 1'b1;
               end
            end
         end
      end
      if (m_run) begin
         e.valid = 1'b1;
         e.busy  = 1'b1;
         e.a     = m_dir ? 3'(7 - m_k) : 3'(m_k);
      end
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({a, valid, busy, done, wrap} !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got a=%0d valid=%b busy=%b done=%b wrap=%b, expected a=%0d valid=%b busy=%b done=%b wrap=%b",
                     cycle, a, valid, busy, done, wrap, e.a, e.valid, e.busy, e.done, e.wrap);
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0; hold = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(2);

      // One-shot up sweep to completion.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(36);

      // Continuous down through a wrap, then stop.
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle_cycles(40);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(2);

      // Stop while a=3, then restart.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(13);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(5);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // start+stop together in IDLE, then start ignored during RUN at a=2.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(2);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(9);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle_cycles(6);

      // Reset during RUN with a=5.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(22);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(2);

      // Hold for 5 cycles at a=4 (no effect unless the hold input exists).
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_cycles(17);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle_cycles(20);

      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 5) == 0));
      end

      repeat (2) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
